// File: rtl/lshift_pkg.sv
// lshift_pkg
// Shared definitions for the multi-cycle left-shift sequencer:
//   state_t      controller state encoding (IDLE / SHIFT / DONE)
//   DEF_WIDTH    default operand/result width
//   DEF_AMT_W    default shift-amount width (2**DEF_AMT_W == DEF_WIDTH)
//   STEP4        stride of the wide step used when LSHIFT_SEQ_STEP4_EN is defined
package lshift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_AMT_W = 5;
  localparam int STEP4     = 4;

endpackage

// File: rtl/lshift_step.sv
// lshift_step
// Combinational single-step left shifter; zeros enter at the LSB.
// Configuration macro: LSHIFT_SEQ_STEP4_EN
//   undefined : out_data = in_data << 1 (no step-select port, no 4-bit path)
//   defined   : out_data = in_data << 4 when step4 is set, else << 1
// Ports:
//   data     [WIDTH-1:0]  value to shift
//   step4                 select the 4-bit stride (macro builds only)
//   shifted  [WIDTH-1:0]  shifted value
module lshift_step
  import lshift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
`ifdef LSHIFT_SEQ_STEP4_EN
  input  logic             step4,
`endif
  output logic [WIDTH-1:0] shifted
);

`ifdef LSHIFT_SEQ_STEP4_EN
  always_comb begin
    shifted = data << 1;
    if (step4) begin
      shifted = data << STEP4;
    end
  end
`else
  assign shifted = data << 1;
`endif

endmodule

// File: rtl/lshift_sequencer.sv
// lshift_sequencer
// Multi-cycle controller that drives a single-step left shifter to produce a
// logical left shift by 0..WIDTH-1 positions. One operation in flight.
// Configuration macro: LSHIFT_SEQ_STEP4_EN (steps of 4 while at least 4 remain).
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid / in_ready      operand handshake (ready only while IDLE)
//   in_data  [WIDTH-1:0]     operand, sampled at the accept edge only
//   in_amt   [AMT_W-1:0]     shift amount, sampled at the accept edge only
//   out_valid / out_ready    result handshake (valid only while DONE)
//   out_data [WIDTH-1:0]     working register; meaningful when out_valid=1
//   busy                     high while SHIFT or DONE
// AMT_W must satisfy 2**AMT_W == WIDTH.
module lshift_sequencer
  import lshift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state_q, state_next;
  logic [WIDTH-1:0] data_q, data_next;
  logic [AMT_W-1:0] cnt_q, cnt_next;

  logic [WIDTH-1:0] step_data;
  logic [AMT_W-1:0] step_amt;

`ifdef LSHIFT_SEQ_STEP4_EN
  logic step4;

  // Take the wide stride whenever it cannot overshoot the remaining count.
  assign step4    = (cnt_q >= AMT_W'(STEP4));
  assign step_amt = step4 ? AMT_W'(STEP4) : AMT_W'(1);

  lshift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data    (data_q),
    .step4   (step4),
    .shifted (step_data)
  );
`else
  assign step_amt = AMT_W'(1);

  lshift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data    (data_q),
    .shifted (step_data)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_next;
      data_q  <= data_next;
      cnt_q   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_q;
    data_next  = data_q;
    cnt_next   = cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_next  = in_data;
          cnt_next   = in_amt;
          // A zero amount needs no shift step, so the result is ready at once.
          state_next = (in_amt == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        busy      = 1'b1;
        data_next = step_data;
        // cnt_q >= 1 here, and the stride never exceeds cnt_q, so no underflow.
        cnt_next  = cnt_q - step_amt;
        if (cnt_next == '0) begin
          state_next = DONE;
        end
      end

      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_lshift_sequencer.sv
// tb_lshift_sequencer
// Directed and randomized checks of lshift_sequencer against a reference model
// that computes the result as operand * 2**amt (truncated) and the latency
// from the shift-amount formula of the selected build.
`timescale 1ns/1ps
module tb_lshift_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  lshift_sequencer #(
    .WIDTH (32),
    .AMT_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int a);
`ifdef LSHIFT_SEQ_STEP4_EN
    return (a / 4) + (a % 4);
`else
    return a;
`endif
  endfunction

  function automatic logic [31:0] exp_result(input logic [31:0] d, input int a);
    logic [31:0] scale;
    scale = 32'd1;
    for (int i = 0; i < a; i++) scale = scale * 32'd2;
    return d * scale;
  endfunction

  // Called #1 after a rising edge with the DUT expected idle.
  task automatic do_op(input logic [31:0] d, input logic [4:0] a, input int stall);
    logic [31:0] exp_d;
    int          lat;
    int          guard;
    exp_d = exp_result(d, int'(a));
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    @(posedge clk); #1;
    // Operand changes after the accept edge must have no effect.
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = 5'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      check("busy_shift", 32'(busy), 32'd1);
      check("ready_shift", 32'(in_ready), 32'd0);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat(int'(a))));
    check("result", out_data, exp_d);
    check("busy_done", 32'(busy), 32'd1);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, exp_d);
    end
    out_ready = 1'b1;
    in_valid  = 1'($urandom);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    $display("op data=%h amt=%0d stall=%0d lat=%0d result=%h expected=%h",
             d, a, stall, lat, out_data, exp_d);
  endtask

  initial begin
    int seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", out_data, 32'd0);

    // Directed operations
    do_op(32'h96969696, 5'd1, 0);
    do_op(32'h3A3A3A3A, 5'd0, 0);
    do_op(32'h3A3A3A3A, 5'd4, 0);
    do_op(32'hE6E6E6E7, 5'd31, 3);

    // Reset while an operation is in progress discards it.
    in_valid = 1'b1;
    in_data  = 32'h12345679;
    in_amt   = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    seen_valid = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    check("mid_rst_no_output", 32'(seen_valid), 32'd0);
    do_op(32'h00000001, 5'd5, 0);

    // Reset and in_valid together: nothing is accepted.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hFFFF0000;
    in_amt   = 5'd3;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_valid_busy", 32'(busy), 32'd0);
    check("rst_vs_valid_ready", 32'(in_ready), 32'd1);
    check("rst_vs_valid_data", out_data, 32'd0);

    // Randomized back-to-back operations with output stalls
    for (int n = 0; n < 60; n++) begin
      do_op($urandom, 5'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lshift_sequencer.md
Name: lshift_sequencer

Overview:
- Multi-cycle controller that sequences a single-step 32-bit left shifter to produce a left shift by 0..31 bit positions.
- Sits between the ALU operand/issue logic and the logic unit's shift path.
- Accepts an operand and a shift amount over a valid/ready handshake, then iterates one shift step per cycle.
- Returns the result over a second valid/ready handshake.

Parameters:
WIDTH, 32, operand/result width in bits
AMT_W, 5, shift-amount width; must satisfy 2**AMT_W == WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand and amount presented
in_ready  output  1  sequencer can accept (high only in IDLE)
in_data  input  WIDTH  operand to shift
in_amt  input  AMT_W  left-shift amount, 0..WIDTH-1
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result; zeros enter at LSB
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset, synchronous on rst=1 at a rising edge, applied in any state:
  - state=IDLE, data register=0, count=0
  - out_valid=0, out_data=0, busy=0, in_ready=1 in the following cycle
  - An operation in progress is discarded with no output.
- States:
  - IDLE: in_ready=1, busy=0. Accept on in_valid&&in_ready: latch in_data into data_q and in_amt into cnt_q. Go to DONE if in_amt==0, else to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each cycle: data_q <= data_q<<1 with LSB=0; cnt_q <= cnt_q-1. When cnt_q==1, go to DONE with this edge's shift applied.
  - DONE: out_valid=1, out_data=data_q, busy=1, in_ready=0. On out_ready=1, go to IDLE; out_valid drops the next cycle. Otherwise hold data and out_valid stable.
- Latency: accept at edge k gives out_valid=1 from edge k+in_amt onward. For amt=0 this is the cycle right after the accept.
- Throughput: one operation in flight.
  - No new accept in the same cycle as the output handshake; the earliest next accept is the cycle after returning to IDLE.
  - Minimum turnaround is amt+2 cycles.
- in_valid is ignored while in SHIFT or DONE. in_data and in_amt are sampled only at the accept edge; later changes have no effect.
- out_data equals data_q in every state; consumers qualify it with out_valid only.
- Arithmetic:
  - The shift is logical; bits shifted past the MSB are lost.
  - The result equals in_data << in_amt truncated to WIDTH.
  - cnt_q never underflows: SHIFT is entered only with cnt_q>=1.
- Simultaneous rst and in_valid: rst wins, nothing is accepted.
- Simultaneous rst and out_ready in DONE: rst wins; the result is counted as not delivered.

Optional Feature:
- Macro: LSHIFT_SEQ_STEP4_EN.
- With the macro defined, a SHIFT cycle with cnt_q>=4 shifts by 4 and subtracts 4; otherwise it shifts by 1 and subtracts 1.
- DONE is entered when the step brings cnt_q to 0.
- Latency becomes (amt>>2) + (amt&3) cycles, with amt=0 still 0 extra.
- Results are identical to the macro-absent case.
- Without the macro: one bit per cycle only; the 4-bit path is not present in the netlist.

Decomposition:
- Shared package lshift_pkg:
  - state enum: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10
  - WIDTH and AMT_W default constants
  - STEP4 constant = 4
- One sub-module, lshift_step: a combinational single-step shifter.
  - Inputs: data, step-select. Output: data shifted by 1, or by 4 when step-select is set under the macro.
  - Instantiated once in lshift_sequencer; the FSM and counter stay in the parent.

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, busy=0, out_data=0.
- in_data=32'h96969696, in_amt=1, out_ready=1 → out_valid after 1 cycle, out_data=32'h2D2D2D2C; back in IDLE the next cycle.
- in_data=32'h3A3A3A3A, in_amt=0 → out_valid the cycle after accept, out_data=32'h3A3A3A3A. Then in_amt=4 → out_data=32'hA3A3A3A0 after 4 cycles (1 cycle with LSHIFT_SEQ_STEP4_EN).
- in_data=32'hE6E6E6E7, in_amt=31 → out_data=32'h80000000 after 31 cycles (10 with the macro). Hold out_ready=0 for 3 cycles: out_valid and out_data stay stable. in_valid pulses during SHIFT/DONE are ignored.
- rst asserted mid-SHIFT (amt=20, cycle 7) → next cycle IDLE, out_valid=0, data 0. The next operation (32'h00000001, amt=5) yields 32'h00000020.
- Randomized back-to-back operations with random out_ready stalls → out_data == (in_data<<in_amt), with latency matching the formula for the build.
